bus_mux_reg: RTL and testbench

- Parametrised, registered successor to the processor's combinational bus multiplexer. It drives BusWires from one of NUM_REGS register outputs, the G accumulator or DIN.
- Adds a fixed priority scheme, a one-cycle registered bus and last-value hold when idle, so the bus never goes X.
- Detects multi-driver select conflicts with a sticky flag and a saturating counter that the control FSM and the testbench monitor.

---
 rtl/bus_mux_reg_if.sv | 31 +++
 rtl/bus_mux_reg.sv | 100 ++++++++++
 tb/tb_bus_mux_reg.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/bus_mux_reg_if.sv
// Bus multiplexer interface: source selects and data in, registered bus and conflict status out.
interface bus_mux_reg_if #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned CNT_W    = 8
);
  localparam int unsigned SRC_W = $clog2(NUM_REGS + 2);

  logic [NUM_REGS-1:0]        Rout;
  logic                       Gout;
  logic                       DINout;
  logic [NUM_REGS*DATA_W-1:0] R_data;
  logic [DATA_W-1:0]          G_data;
  logic [DATA_W-1:0]          DIN_data;
  logic                       clr_err;
  logic [DATA_W-1:0]          BusWires;
  logic                       bus_valid;
  logic [SRC_W-1:0]           bus_src;
  logic                       conflict;
  logic [CNT_W-1:0]           conflict_cnt;

  modport master (
    output Rout, Gout, DINout, R_data, G_data, DIN_data, clr_err,
    input  BusWires, bus_valid, bus_src, conflict, conflict_cnt
  );

  modport slave (
    input  Rout, Gout, DINout, R_data, G_data, DIN_data, clr_err,
    output BusWires, bus_valid, bus_src, conflict, conflict_cnt
  );
endinterface

// File: rtl/bus_mux_reg.sv
// Registered, priority-encoded bus multiplexer with idle hold and sticky
// multi-driver conflict detection (flag plus saturating counter).
module bus_mux_reg #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned CNT_W    = 8
) (
  input logic          Clock,
  input logic          Resetn,
  bus_mux_reg_if.slave mux_if
);
  localparam int unsigned SRC_W = $clog2(NUM_REGS + 2);
  localparam int unsigned ACT_W = $clog2(NUM_REGS + 3);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] DRIVE = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [DATA_W-1:0] bus_q, bus_d;
  logic [SRC_W-1:0]  src_q, src_d;
  logic              conflict_q, conflict_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [ACT_W-1:0]  act_cnt_c;
  logic [DATA_W-1:0] win_data_c;
  logic [SRC_W-1:0]  win_src_c;
  logic              any_sel_c;
  logic              multi_sel_c;

  // Active-source count and priority winner; later assignments take precedence.
  always_comb begin
    act_cnt_c  = ACT_W'(mux_if.DINout) + ACT_W'(mux_if.Gout);
    win_data_c = '0;
    win_src_c  = '0;
    for (int i = int'(NUM_REGS) - 1; i >= 0; i--) begin
      act_cnt_c = act_cnt_c + ACT_W'(mux_if.Rout[int'(NUM_REGS) - 1 - i]);
      if (mux_if.Rout[int'(NUM_REGS) - 1 - i]) begin
        win_data_c = mux_if.R_data[i*int'(DATA_W) +: DATA_W];
        win_src_c  = SRC_W'(i);
      end
    end
    if (mux_if.Gout) begin
      win_data_c = mux_if.G_data;
      win_src_c  = SRC_W'(NUM_REGS);
    end
    if (mux_if.DINout) begin
      win_data_c = mux_if.DIN_data;
      win_src_c  = SRC_W'(NUM_REGS + 1);
    end
    any_sel_c   = (act_cnt_c != '0);
    multi_sel_c = (act_cnt_c > ACT_W'(1));
  end

  // Next state: IDLE holds bus/src; a conflict overrides a same-cycle clear.
  always_comb begin
    state_d    = IDLE;
    bus_d      = bus_q;
    src_d      = src_q;
    conflict_d = conflict_q;
    cnt_d      = cnt_q;
    if (any_sel_c) begin
      state_d = DRIVE;
      bus_d   = win_data_c;
      src_d   = win_src_c;
    end
    if (multi_sel_c) begin
      conflict_d = 1'b1;
      if (mux_if.clr_err) begin
        cnt_d = CNT_W'(1);
      end else if (cnt_q != {CNT_W{1'b1}}) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (mux_if.clr_err) begin
      conflict_d = 1'b0;
      cnt_d      = '0;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= IDLE;
      bus_q      <= '0;
      src_q      <= '0;
      conflict_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      bus_q      <= bus_d;
      src_q      <= src_d;
      conflict_q <= conflict_d;
      cnt_q      <= cnt_d;
    end
  end

  assign mux_if.BusWires     = bus_q;
  assign mux_if.bus_valid    = (state_q == DRIVE);
  assign mux_if.bus_src      = src_q;
  assign mux_if.conflict     = conflict_q;
  assign mux_if.conflict_cnt = cnt_q;
endmodule

// File: tb/tb_bus_mux_reg.sv
// Directed bench for bus_mux_reg: scoreboarded 8-register instance plus a 4-register, 8-bit variant.
module tb_bus_mux_reg;
  logic clk;
  logic rst_n;

  bus_mux_reg_if #(.DATA_W(16), .NUM_REGS(8), .CNT_W(8)) u_if8 ();
  bus_mux_reg_if #(.DATA_W(8),  .NUM_REGS(4), .CNT_W(8)) u_if4 ();

  bus_mux_reg #(.DATA_W(16), .NUM_REGS(8), .CNT_W(8)) u_dut8 (
    .Clock(clk), .Resetn(rst_n), .mux_if(u_if8.slave));
  bus_mux_reg #(.DATA_W(8), .NUM_REGS(4), .CNT_W(8)) u_dut4 (
    .Clock(clk), .Resetn(rst_n), .mux_if(u_if4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bus;
    logic [3:0]  src;
    logic        valid;
    logic        conf;
    logic [7:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  logic [15:0] m_bus;
  logic [3:0]  m_src;
  logic        m_conf;
  logic [7:0]  m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_cmp++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s observed=%h required=%h", tag, obs, req);
    end
  endtask

  task automatic model_reset();
    m_bus = '0; m_src = '0; m_conf = 1'b0; m_cnt = '0;
  endtask

  // Reference model for the 8-register instance; pushes the expected post-edge outputs.
  task automatic push_expect();
    exp_t e;
    int   active;
    int   idx;
    active = int'(u_if8.DINout) + int'(u_if8.Gout) + $countones(u_if8.Rout);
    idx = -1;
    for (int b = 7; b >= 0; b--) begin
      if (idx < 0 && u_if8.Rout[b]) idx = 7 - b;
    end
    if (u_if8.DINout) begin
      m_bus = u_if8.DIN_data; m_src = 4'd9;
    end else if (u_if8.Gout) begin
      m_bus = u_if8.G_data; m_src = 4'd8;
    end else if (idx >= 0) begin
      m_bus = u_if8.R_data[idx*16 +: 16]; m_src = 4'(idx);
    end
    if (active > 1) begin
      m_conf = 1'b1;
      if (u_if8.clr_err) m_cnt = 8'd1;
      else if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
    end else if (u_if8.clr_err) begin
      m_conf = 1'b0; m_cnt = 8'd0;
    end
    e.bus = m_bus; e.src = m_src; e.valid = (active > 0);
    e.conf = m_conf; e.cnt = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    push_expect();
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("bus",       32'(u_if8.BusWires),     32'(e.bus));
      chk("src",       32'(u_if8.bus_src),      32'(e.src));
      chk("valid",     32'(u_if8.bus_valid),    32'(e.valid));
      chk("conflict",  32'(u_if8.conflict),     32'(e.conf));
      chk("cnt",       32'(u_if8.conflict_cnt), 32'(e.cnt));
    end
  endtask

  task automatic idle8();
    u_if8.Rout = '0; u_if8.Gout = 1'b0; u_if8.DINout = 1'b0; u_if8.clr_err = 1'b0;
  endtask

  task automatic chk_zero8(input string tag);
    chk({tag, "_bus"},   32'(u_if8.BusWires),     32'd0);
    chk({tag, "_valid"}, 32'(u_if8.bus_valid),    32'd0);
    chk({tag, "_src"},   32'(u_if8.bus_src),      32'd0);
    chk({tag, "_conf"},  32'(u_if8.conflict),     32'd0);
    chk({tag, "_cnt"},   32'(u_if8.conflict_cnt), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle8();
    u_if8.R_data = '0; u_if8.G_data = '0; u_if8.DIN_data = '0;
    u_if4.Rout = '0; u_if4.Gout = 1'b0; u_if4.DINout = 1'b0; u_if4.clr_err = 1'b0;
    u_if4.R_data = {8'h5A, 8'h33, 8'h22, 8'h11};
    u_if4.G_data = 8'hC3; u_if4.DIN_data = 8'h3C;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_zero8("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;

    // 1. reset mid-operation, then release idle
    u_if8.DINout = 1'b1; u_if8.DIN_data = 16'h1234;
    step();
    chk("pre_rst_bus", 32'(u_if8.BusWires), 32'h1234);
    idle8();
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_zero8("rst_async");
    @(posedge clk);
    #1;
    chk_zero8("rst_low_edge");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();

    // 2. register sweep, R0 (MSB of Rout) down to R7
    for (int i = 0; i < 8; i++) u_if8.R_data[i*16 +: 16] = 16'hA000 + 16'(i);
    for (int k = 0; k < 8; k++) begin
      u_if8.Rout = 8'h80 >> k;
      step();
      chk("sweep_bus", 32'(u_if8.BusWires), 32'hA000 + 32'(k));
      chk("sweep_src", 32'(u_if8.bus_src), 32'(k));
    end

    // 3. priority and conflict counting
    u_if8.DINout = 1'b1; u_if8.Gout = 1'b1; u_if8.Rout = 8'b0010_0000;
    u_if8.DIN_data = 16'hBEEF;
    step();
    chk("prio_bus", 32'(u_if8.BusWires), 32'hBEEF);
    chk("prio_src", 32'(u_if8.bus_src), 32'd9);
    chk("prio_cnt", 32'(u_if8.conflict_cnt), 32'd1);
    u_if8.DINout = 1'b0; u_if8.Gout = 1'b0; u_if8.Rout = 8'b0100_0100;
    step();
    chk("rr_bus", 32'(u_if8.BusWires), 32'hA001);
    chk("rr_src", 32'(u_if8.bus_src), 32'd1);
    chk("rr_cnt", 32'(u_if8.conflict_cnt), 32'd2);

    // 4. idle hold ignores later source changes
    idle8();
    u_if8.Gout = 1'b1; u_if8.G_data = 16'h00FF;
    step();
    idle8();
    u_if8.G_data = 16'h1111;
    step();
    chk("hold_bus", 32'(u_if8.BusWires), 32'h00FF);
    chk("hold_src", 32'(u_if8.bus_src), 32'd8);
    chk("hold_valid", 32'(u_if8.bus_valid), 32'd0);
    step();

    // 5. saturation and clear
    u_if8.Gout = 1'b1; u_if8.DINout = 1'b1;
    repeat (300) step();
    chk("sat_cnt", 32'(u_if8.conflict_cnt), 32'd255);
    idle8();
    u_if8.clr_err = 1'b1;
    step();
    chk("clr_conf", 32'(u_if8.conflict), 32'd0);
    chk("clr_cnt", 32'(u_if8.conflict_cnt), 32'd0);
    u_if8.clr_err = 1'b0;
    step();
    u_if8.clr_err = 1'b1; u_if8.Gout = 1'b1; u_if8.DINout = 1'b1;
    step();
    chk("clrc_conf", 32'(u_if8.conflict), 32'd1);
    chk("clrc_cnt", 32'(u_if8.conflict_cnt), 32'd1);
    idle8();
    step();

    // 6. 4-register, 8-bit variant
    u_if4.Rout = 4'b0001;
    @(posedge clk); #1;
    chk("v4_r_bus", 32'(u_if4.BusWires), 32'h5A);
    chk("v4_r_src", 32'(u_if4.bus_src), 32'd3);
    chk("v4_r_valid", 32'(u_if4.bus_valid), 32'd1);
    u_if4.Rout = 4'b0000; u_if4.Gout = 1'b1;
    @(posedge clk); #1;
    chk("v4_g_bus", 32'(u_if4.BusWires), 32'hC3);
    chk("v4_g_src", 32'(u_if4.bus_src), 32'd4);
    u_if4.Gout = 1'b0; u_if4.DINout = 1'b1;
    @(posedge clk); #1;
    chk("v4_d_bus", 32'(u_if4.BusWires), 32'h3C);
    chk("v4_d_src", 32'(u_if4.bus_src), 32'd5);
    chk("v4_d_conf", 32'(u_if4.conflict), 32'd0);
    u_if4.DINout = 1'b0;
    @(posedge clk); #1;
    chk("v4_idle_valid", 32'(u_if4.bus_valid), 32'd0);
    chk("v4_idle_src", 32'(u_if4.bus_src), 32'd5);

    if (exp_q.size() != 0) chk("scoreboard_left", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
